// File: rtl/mf_disp_evt_arb.sv
// Round-robin scheduler that shares one 4-bit event lane among NUM requesters,
// issuing accumulated {id, nibble} pairs over valid/ready with an idle gap after each issue.
module mf_disp_evt_arb #(
    parameter int NUM     = 4,
    parameter int MIN_GAP = 2
) (
    input  logic                    clk_a,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM-1:0]        req_evt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_data,
    output logic [$clog2(NUM)-1:0]  out_id,
    output logic [NUM-1:0]          ovf,
    input  logic [NUM-1:0]          ovf_clr,
    output logic                    busy
);

    localparam int ID_W = $clog2(NUM);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM-1:0][3:0]    pend_q, pend_d;
    logic [NUM-1:0][3:0]    req_arr;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [3:0]             out_data_q, out_data_d;
    logic [ID_W-1:0]        out_id_q, out_id_d;
    logic [NUM-1:0]         ovf_q, ovf_d;

    logic                   grant_found;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W:0]          scan_idx;

    assign req_arr = req_evt;

    // Scan from ptr upward, wrapping modulo NUM, for the first requester with pending events.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM; k++) begin
            scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM);
            end
            if (!grant_found && (pend_q[scan_idx[ID_W-1:0]] != 4'h0)) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ptr_d       = ptr_q;
        gap_cnt_d   = gap_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ovf_d       = ovf_q & ~ovf_clr;

        // A new event bit landing on an already-pending bit merges but flags overflow; set beats clear.
        for (int i = 0; i < NUM; i++) begin
            if ((pend_q[i] & req_arr[i]) != 4'h0) begin
                ovf_d[i] = 1'b1;
            end
            pend_d[i] = pend_q[i] | req_arr[i];
        end

        case (state_q)
            IDLE: begin
                if (en && grant_found) begin
                    out_data_d         = pend_q[grant_id];
                    out_id_d           = grant_id;
                    out_valid_d        = 1'b1;
                    pend_d[grant_id]   = req_arr[grant_id];
                    state_d            = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = (out_id_q == ID_W'(NUM-1)) ? '0 : out_id_q + ID_W'(1);
                    if (MIN_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = 4'(MIN_GAP-1);
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            ptr_q       <= '0;
            gap_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE) || (|pend_q);

endmodule

// File: tb/tb_mf_disp_evt_arb.sv
// Scoreboard bench for mf_disp_evt_arb: a timestamp-based reference model predicts issues
// into a queue, and a negedge monitor pops and compares on every handshake.
module tb_mf_disp_evt_arb;

    localparam int NUM     = 4;
    localparam int MIN_GAP = 2;
    localparam int ID_W    = $clog2(NUM);

    logic                 clk_a = 1'b0;
    logic                 rst;
    logic                 en;
    logic [4*NUM-1:0]     req_evt;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_data;
    logic [ID_W-1:0]      out_id;
    logic [NUM-1:0]       ovf;
    logic [NUM-1:0]       ovf_clr;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    always #5 clk_a = ~clk_a;

    mf_disp_evt_arb #(
        .NUM     (NUM),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .clk_a     (clk_a),
        .rst       (rst),
        .en        (en),
        .req_evt   (req_evt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int data;
    } issue_t;

    issue_t exp_q[$];

    int m_pend[NUM];
    int m_ptr;
    int m_last_id;
    int m_allow;
    int m_cycle = 0;
    bit m_inflight;
    bit [NUM-1:0] m_ovf;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4*NUM-1:0] r, input logic e, input logic rdy,
                                 input logic [NUM-1:0] clr, input logic rs, input int n);
        req_evt   = r;
        en        = e;
        out_ready = rdy;
        ovf_clr   = clr;
        rst       = rs;
        repeat (n) @(posedge clk_a);
        #1;
    endtask

    // Reference model: grants allowed once the post-accept idle window (tracked as a cycle
    // timestamp) has elapsed; each grant pushes its expected {id, nibble} into the scoreboard.
    always @(posedge clk_a) begin : model
        int g;
        int idx;
        int r;
        m_cycle++;
        if (rst) begin
            for (int i = 0; i < NUM; i++) m_pend[i] = 0;
            m_ptr      = 0;
            m_last_id  = 0;
            m_allow    = 0;
            m_inflight = 1'b0;
            m_ovf      = '0;
            exp_q.delete();
        end else begin
            g = -1;
            if (m_inflight) begin
                if (out_ready) begin
                    m_inflight = 1'b0;
                    m_ptr      = (m_last_id + 1) % NUM;
                    m_allow    = m_cycle + MIN_GAP + 1;
                end
            end else if (m_cycle >= m_allow && en) begin
                for (int k = 0; k < NUM; k++) begin
                    idx = (m_ptr + k) % NUM;
                    if (g < 0 && m_pend[idx] != 0) g = idx;
                end
                if (g >= 0) begin
                    exp_q.push_back('{id: g, data: m_pend[g]});
                    m_inflight = 1'b1;
                    m_last_id  = g;
                end
            end
            for (int i = 0; i < NUM; i++) begin
                r = int'((req_evt >> (4*i)) & 16'hF);
                if ((r & m_pend[i]) != 0) m_ovf[i] = 1'b1;
                else if (ovf_clr[i]) m_ovf[i] = 1'b0;
                m_pend[i] = (i == g) ? r : (m_pend[i] | r);
            end
        end
    end

    // Monitor: per-cycle status comparison plus scoreboard pop on each accepted issue.
    bit       prev_valid = 1'b0;
    bit       prev_ready = 1'b0;
    int       prev_data  = 0;
    int       prev_id    = 0;

    always @(negedge clk_a) begin : monitor
        issue_t exp_item;
        bit     m_busy;
        if (mon_en) begin
            m_busy = m_inflight || (m_cycle < m_allow - 1);
            for (int i = 0; i < NUM; i++) if (m_pend[i] != 0) m_busy = 1'b1;
            checkOutput("out_valid", int'(out_valid), int'(m_inflight));
            checkOutput("busy", int'(busy), int'(m_busy));
            checkOutput("ovf", int'(ovf), int'(m_ovf));
            if (prev_valid && !prev_ready && out_valid) begin
                checkOutput("hold_data", int'(out_data), prev_data);
                checkOutput("hold_id", int'(out_id), prev_id);
            end
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_issue actual id=%0d data=%0d required none", out_id, out_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    checkOutput("issue_id", int'(out_id), exp_item.id);
                    checkOutput("issue_data", int'(out_data), exp_item.data);
                end
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = int'(out_data);
        prev_id    = int'(out_id);
    end

    initial begin
        logic [4*NUM-1:0] r;
        logic [NUM-1:0]   c;

        // Reset held with every request bit set; nothing may be latched.
        applyStimulus('1, 1'b1, 1'b1, '0, 1'b1, 2);
        mon_en = 1'b1;
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 1);
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_id", int'(out_id), 0);
        checkOutput("rst_data", int'(out_data), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        checkOutput("rst_busy", int'(busy), 0);

        // Single event on requester 1.
        applyStimulus(16'h0050, 1'b1, 1'b1, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 10);

        // All four together, then 0 and 3.
        applyStimulus(16'h1111, 1'b1, 1'b1, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 20);
        applyStimulus(16'h1001, 1'b1, 1'b1, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 12);

        // Backpressure while an arrival accumulates for the same requester.
        applyStimulus(16'h0008, 1'b1, 1'b0, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b0, '0, 1'b0, 3);
        applyStimulus(16'h0002, 1'b1, 1'b0, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b0, '0, 1'b0, 6);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 12);

        // Overflow and merge with grants held off.
        applyStimulus(16'h0001, 1'b0, 1'b1, '0, 1'b0, 1);
        applyStimulus(16'h0001, 1'b0, 1'b1, '0, 1'b0, 1);
        applyStimulus('0, 1'b0, 1'b1, '0, 1'b0, 2);
        checkOutput("ovf0_set", int'(ovf[0]), 1);
        checkOutput("busy_en_low", int'(busy), 1);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 8);
        applyStimulus(16'h0001, 1'b0, 1'b1, '0, 1'b0, 1);
        applyStimulus(16'h0002, 1'b0, 1'b1, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 8);
        applyStimulus('0, 1'b1, 1'b1, 4'b0001, 1'b0, 1);
        checkOutput("ovf0_clr", int'(ovf[0]), 0);

        // Reset while an issue is outstanding drops it and all pending events.
        applyStimulus(16'h0030, 1'b1, 1'b0, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b0, '0, 1'b0, 3);
        applyStimulus(16'h0400, 1'b1, 1'b0, '0, 1'b0, 1);
        applyStimulus('0, 1'b1, 1'b0, '0, 1'b1, 1);
        checkOutput("midrst_valid", int'(out_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 12);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r = '0;
            c = '0;
            for (int i = 0; i < NUM; i++) begin
                if ($urandom % 6 == 0) r[4*i +: 4] = 4'($urandom_range(15, 1));
                if ($urandom % 10 == 0) c[i] = 1'b1;
            end
            applyStimulus(r, ($urandom % 8) != 0, ($urandom % 4) != 0, c,
                          ($urandom % 400) == 0, 1);
        end

        applyStimulus('0, 1'b1, 1'b1, '0, 1'b0, 40);
        checkOutput("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
